// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and sequencer for a
// single-port synchronous data memory. One transaction at a time is latched,
// issued for a single cycle, optionally waited on for RD_LAT cycles, and
// completed with a one-cycle ack to the owning requester.
module mem_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t        r_state;
  state_t        w_next;
  logic          w_take;
  logic          w_pick;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_grant;
  logic          r_last;
  logic [2:0]    r_cnt;
  logic          r_ack0;
  logic          r_ack1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  // Next-state and arbitration decision; the winner alternates on contention.
  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    w_pick = 1'b0;
    case (r_state)
      IDLE: begin
        w_take = req0 | req1;
        if (req0 && req1) w_pick = ~r_last;
        else              w_pick = req1;
        if (w_take) w_next = ISSUE;
      end
      ISSUE:   w_next = r_we ? DONE : WAIT;
      WAIT:    if (r_cnt == 3'd1) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Latch the winner's command so later input changes cannot reach memory.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_grant <= 1'b0;
    end else if (r_state == IDLE && w_take) begin
      r_we    <= w_pick ? we1    : we0;
      r_addr  <= w_pick ? addr1  : addr0;
      r_wdata <= w_pick ? wdata1 : wdata0;
      r_grant <= w_pick;
    end
  end

  // Read-latency counter: loaded on issue, counts down through WAIT.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn)                 r_cnt <= '0;
    else if (r_state == ISSUE)  r_cnt <= LAT;
    else if (r_state == WAIT)   r_cnt <= r_cnt - 3'd1;
  end

  // Capture read data for the owner in the final WAIT cycle; writes leave it alone.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == WAIT && r_cnt == 3'd1) begin
      if (r_grant) r_rdata1 <= mem_rdata;
      else         r_rdata0 <= mem_rdata;
    end
  end

  // Registered completion pulse, high exactly for the DONE cycle.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
    end else begin
      r_ack0 <= (w_next == DONE) && !r_grant;
      r_ack1 <= (w_next == DONE) &&  r_grant;
    end
  end

  // Remember the last completed owner; starts at 1 so requester 0 wins first.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn)                r_last <= 1'b1;
    else if (r_state == DONE)  r_last <= r_grant;
  end

  assign mem_en    = (r_state == ISSUE);
  assign mem_we    = (r_state == ISSUE) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != IDLE);
  assign grant_id  = r_grant;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=3 (main) and one
// with RD_LAT=1, sharing stimulus, each with its own memory model.
module tb_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;

  logic        ack0, ack1, mem_en, mem_we, busy, grant_id;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        ack0_b, ack1_b, mem_en_b, mem_we_b, busy_b, grant_id_b;
  logic [15:0] rdata0_b, rdata1_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  mem_arbiter #(.AW(16), .DW(16), .RD_LAT(3)) u_dut (
    .Clock(Clock), .Resetn(Resetn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) u_dut1 (
    .Clock(Clock), .Resetn(Resetn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_b), .rdata0(rdata0_b),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_b), .rdata1(rdata1_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b), .grant_id(grant_id_b)
  );

  // Unwritten locations read as {C3, addr[7:0]}, except 0x20 which holds 0x1234.
  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h20) ? 16'h1234 : {8'hC3, a};
  endfunction

  bit   [15:0] mem3 [256];
  bit          wr3  [256];
  logic [15:0] p3   [3];
  bit   [15:0] mem1 [256];
  bit          wr1  [256];
  logic [15:0] p1;

  // Memory for the RD_LAT=3 instance: data appears 3 edges after issue.
  always @(posedge Clock) begin
    if (mem_en && mem_we) begin
      mem3[mem_addr[7:0]] <= mem_wdata;
      wr3[mem_addr[7:0]]  <= 1'b1;
    end
    p3[0] <= (mem_en && !mem_we) ?
             (wr3[mem_addr[7:0]] ? mem3[mem_addr[7:0]] : init_val(mem_addr[7:0])) : 16'hDEAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata = p3[2];

  // Memory for the RD_LAT=1 instance.
  always @(posedge Clock) begin
    if (mem_en_b && mem_we_b) begin
      mem1[mem_addr_b[7:0]] <= mem_wdata_b;
      wr1[mem_addr_b[7:0]]  <= 1'b1;
    end
    p1 <= (mem_en_b && !mem_we_b) ?
          (wr1[mem_addr_b[7:0]] ? mem1[mem_addr_b[7:0]] : init_val(mem_addr_b[7:0])) : 16'hDEAD;
  end
  assign mem_rdata_b = p1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b0;
  endtask

  // Step up to maxc cycles, dropping requests after the grant; report the ack cycle (0 = none).
  task automatic wait_ack(input bit id, input int maxc, output int cyc);
    cyc = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge Clock);
      if (c == 1) begin req0 = 1'b0; req1 = 1'b0; end
      if (cyc == 0 && (id ? ack1 : ack0)) cyc = c;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, cyc1, cyc3, nen, nack, berr, both, nrst;
    logic [15:0] rd1, rd3;
    logic [3:0] order;

    // Reset state
    do_reset();
    @(negedge Clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_acks", 32'({ack0, ack1}), 32'd0);
    chk("rst_mem_en", 32'({mem_en, mem_we}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);

    // Single write from requester 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
    @(negedge Clock);
    chk("wr_en_we", 32'({mem_en, mem_we}), 32'h3);
    chk("wr_addr", 32'(mem_addr), 32'h0010);
    chk("wr_data", 32'(mem_wdata), 32'hBEEF);
    chk("wr_busy", 32'(busy), 32'd1);
    req0 = 1'b0; we0 = 1'b0;
    @(negedge Clock);
    chk("wr_ack0", 32'(ack0), 32'd1);
    chk("wr_ack1", 32'(ack1), 32'd0);
    chk("wr_en_off", 32'(mem_en), 32'd0);
    @(negedge Clock);
    chk("wr_ack0_pulse", 32'(ack0), 32'd0);
    chk("wr_idle", 32'(busy), 32'd0);

    // Single read from requester 1, both latencies
    do_reset();
    @(negedge Clock);
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
    cyc1 = 0; cyc3 = 0; nen = 0; rd1 = '0; rd3 = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge Clock);
      if (c == 1) req1 = 1'b0;
      if (mem_en) nen++;
      if (ack1 && cyc3 == 0) begin cyc3 = c; rd3 = rdata1; end
      if (ack1_b && cyc1 == 0) begin cyc1 = c; rd1 = rdata1_b; end
    end
    chk("rd_lat1_ack_cyc", 32'(cyc1), 32'd3);
    chk("rd_lat3_ack_cyc", 32'(cyc3), 32'd5);
    chk("rd_lat1_data", 32'(rd1), 32'h1234);
    chk("rd_lat3_data", 32'(rd3), 32'h1234);
    chk("rd_rdata0_kept", 32'({rdata0, rdata0_b}), 32'd0);
    chk("rd_mem_en_once", 32'(nen), 32'd1);

    // Contention after reset, both held high
    do_reset();
    @(negedge Clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0030;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0031;
    nack = 0; order = '0; berr = 0; both = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge Clock);
      if (busy !== ((c % 6) != 0)) berr++;
      if (ack0 && ack1) both++;
      if (ack0) begin if (nack < 4) order[nack] = 1'b0; nack++; end
      if (ack1) begin if (nack < 4) order[nack] = 1'b1; nack++; end
      if (c == 24) begin req0 = 1'b0; req1 = 1'b0; end
    end
    chk("cont_ack_count", 32'(nack), 32'd4);
    chk("cont_order", 32'(order), 32'b1010);
    chk("cont_both_acks", 32'(both), 32'd0);
    chk("cont_busy_pattern", 32'(berr), 32'd0);
    chk("cont_rdata0", 32'(rdata0), 32'hC330);
    chk("cont_rdata1", 32'(rdata1), 32'hC331);

    // Late change of address/command after the grant
    @(negedge Clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
    @(negedge Clock);
    chk("late_issue_addr", 32'(mem_addr), 32'h0005);
    chk("late_issue_en_we", 32'({mem_en, mem_we}), 32'h2);
    addr0 = 16'h0FFF; we0 = 1'b1; wdata0 = 16'h7777; req0 = 1'b0;
    @(negedge Clock);
    chk("late_wait_addr", 32'(mem_addr), 32'h0005);
    wait_ack(1'b0, 4, cyc);
    chk("late_ack_cyc", 32'(cyc), 32'd3);
    chk("late_rdata0", 32'(rdata0), 32'hC305);
    we0 = 1'b0;

    // Reset asserted in the middle of a read
    @(negedge Clock);
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
    @(negedge Clock);
    req1 = 1'b0;
    @(negedge Clock);
    chk("rst_mid_pre_busy", 32'(busy), 32'd1);
    #2 Resetn = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_en", 32'({mem_en, mem_we}), 32'd0);
    chk("rst_mid_acks", 32'({ack0, ack1}), 32'd0);
    chk("rst_mid_rdata", 32'({rdata0, rdata1}), 32'd0);
    @(negedge Clock);
    Resetn = 1'b0;
    nrst = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clock);
      if (ack0 || ack1) nrst++;
    end
    chk("rst_mid_no_ack", 32'(nrst), 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0030;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0031;
    @(negedge Clock);
    chk("rst_first_grant", 32'(grant_id), 32'd0);
    chk("rst_first_addr", 32'(mem_addr), 32'h0030);
    wait_ack(1'b0, 5, cyc);
    chk("rst_first_ack_cyc", 32'(cyc), 32'd4);

    // Write by requester 1, then read back by requester 0
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0040; wdata1 = 16'hA5A5;
    wait_ack(1'b1, 3, cyc);
    chk("wr1_ack_cyc", 32'(cyc), 32'd2);
    chk("wr1_rdata1_kept", 32'(rdata1), 32'd0);
    we1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
    wait_ack(1'b0, 6, cyc);
    chk("rb_ack_cyc", 32'(cyc), 32'd5);
    chk("rb_rdata0", 32'(rdata0), 32'hA5A5);
    chk("rb_rdata1_kept", 32'(rdata1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
